// File: rtl/env_adsr.sv
// ADSR envelope generator with a prescaled update tick and registered outputs.
// Define ENV_EXP_RELEASE_EN to replace the linear i_release step with an exponential-style tail.
module env_adsr #(
    parameter int unsigned PRESCALE = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_gate,
    input  logic [15:0] i_attack,
    input  logic [15:0] i_decay,
    input  logic [15:0] i_sustain,
    input  logic [15:0] i_release,
    output logic [15:0] o_amp,
    output logic [2:0]  o_state,
    output logic        o_active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [15:0] TICK_AT = 16'(PRESCALE - 1);
    localparam logic [15:0] LEVEL_MAX = 16'h7FFF;

    state_t             state;
    logic [15:0]        level;
    logic               active;
    logic [15:0]        cnt;
    logic               gate_q;

    logic               tick;
    logic               rise;
    logic               fall;
    logic [15:0]        sus_c;
    logic [16:0]        att_sum;
    logic signed [16:0] dec_res;
    logic signed [16:0] sus_s;
    logic [15:0]        rel_step;
    logic signed [16:0] rel_res;

    assign tick = (cnt == TICK_AT);
    assign rise = i_gate & ~gate_q;
    assign fall = ~i_gate & gate_q;

    always_comb begin
        sus_c   = i_sustain[15] ? LEVEL_MAX : i_sustain;
        sus_s   = $signed({1'b0, sus_c});
        att_sum = {1'b0, level} + {1'b0, i_attack};
        dec_res = $signed({1'b0, level}) - $signed({1'b0, i_decay});
        rel_res = $signed({1'b0, level}) - $signed({1'b0, rel_step});
    end

`ifdef ENV_EXP_RELEASE_EN
    logic unused_release;
    assign unused_release = ^i_release;
    assign rel_step = {5'b0, level[15:5]} + 16'd1;
`else
    assign rel_step = i_release;
`endif

    // Gate edges pre-empt the tick: the state changes but the level holds for that cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            gate_q <= 1'b0;
            state  <= IDLE;
            level  <= '0;
            active <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + 16'd1;
            gate_q <= i_gate;
            if (rise) begin
                state  <= ATTACK;
                active <= 1'b1;
            end else if (fall) begin
                if (state == ATTACK || state == DECAY || state == SUSTAIN) begin
                    state <= RELEASE;
                end
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        level <= '0;
                    end
                    ATTACK: begin
                        if (i_attack != '0) begin
                            if (att_sum >= {1'b0, LEVEL_MAX}) begin
                                level <= LEVEL_MAX;
                                state <= DECAY;
                            end else begin
                                level <= att_sum[15:0];
                            end
                        end
                    end
                    DECAY: begin
                        if (i_decay != '0) begin
                            if (dec_res <= sus_s) begin
                                level <= sus_c;
                                state <= SUSTAIN;
                            end else begin
                                level <= dec_res[15:0];
                            end
                        end
                    end
                    SUSTAIN: begin
                        level <= sus_c;
                    end
                    RELEASE: begin
                        if (rel_step != '0) begin
                            if (rel_res <= 17'sd0) begin
                                level  <= '0;
                                state  <= IDLE;
                                active <= 1'b0;
                            end else begin
                                level <= rel_res[15:0];
                            end
                        end
                    end
                    default: begin
                        level  <= '0;
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_amp    = level;
    assign o_state  = state;
    assign o_active = active;

endmodule
